// File: rtl/addr_split_if.sv
// Trace-record ingress and split-beat egress bundle for addr_split_queue.
// slave is the queue's view; master is the trace-reader / cache-controller side.
interface addr_split_if #(
  parameter int ADDR_W     = 32,
  parameter int BYTE_SEL_W = 6,
  parameter int INDEX_W    = 14,
  parameter int CMD_W      = 4
);
  localparam int TAG_W = ADDR_W - INDEX_W - BYTE_SEL_W;

  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_W-1:0]     in_addr;
  logic [CMD_W-1:0]      in_cmd;
  logic [BYTE_SEL_W-1:0] in_len;

  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_W-1:0]     out_addr;
  logic [TAG_W-1:0]      out_tag;
  logic [INDEX_W-1:0]    out_index;
  logic [BYTE_SEL_W-1:0] out_byte_sel;
  logic [CMD_W-1:0]      out_cmd;
  logic                  out_last;

  modport master (
    output in_valid, in_addr, in_cmd, in_len, out_ready,
    input  in_ready, out_valid, out_addr, out_tag, out_index, out_byte_sel, out_cmd, out_last
  );

  modport slave (
    input  in_valid, in_addr, in_cmd, in_len, out_ready,
    output in_ready, out_valid, out_addr, out_tag, out_index, out_byte_sel, out_cmd, out_last
  );
endinterface

// File: rtl/addr_split_queue.sv
// Queued trace-record address splitter: DEPTH-entry FIFO feeding a registered beat output.
// Define ADDR_SPLIT_CROSS_EN to split line-crossing accesses into two beats.
//
// state    | meaning
// S_FIRST  | next load is the head's first (or only) beat
// S_SECOND | beat 1 of a crossing head is out; next load is its line-aligned beat 2
module addr_split_queue #(
  parameter int ADDR_W     = 32,
  parameter int BYTE_SEL_W = 6,
  parameter int INDEX_W    = 14,
  parameter int DEPTH      = 4,
  parameter int CMD_W      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  addr_split_if.slave                bus,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int TAG_W  = ADDR_W - INDEX_W - BYTE_SEL_W;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LINE_W = ADDR_W - BYTE_SEL_W;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [CMD_W-1:0]  mem_cmd  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q;

  logic [ADDR_W-1:0] out_addr_q;
  logic [CMD_W-1:0]  out_cmd_q;
  logic              out_valid_q, out_last_q;

  logic push, pop, load;
  logic [ADDR_W-1:0] head_addr;
  logic [CMD_W-1:0]  head_cmd;

  assign bus.in_ready = (count_q != CNT_W'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign load         = (!out_valid_q || bus.out_ready) && (count_q != '0);
  assign head_addr    = mem_addr[rd_ptr];
  assign head_cmd     = mem_cmd[rd_ptr];

`ifdef ADDR_SPLIT_CROSS_EN
  typedef enum logic {S_FIRST, S_SECOND} state_t;
  state_t state;

  logic [BYTE_SEL_W-1:0] mem_len [DEPTH];
  logic [BYTE_SEL_W-1:0] head_len;
  logic [BYTE_SEL_W:0]   end_sum;
  logic [LINE_W-1:0]     next_line;
  logic                  cross;

  assign head_len  = mem_len[rd_ptr];
  assign end_sum   = {1'b0, head_addr[BYTE_SEL_W-1:0]} + {1'b0, head_len};
  assign cross     = end_sum[BYTE_SEL_W];
  // Line number increment wraps past the top of the address space silently.
  assign next_line = head_addr[ADDR_W-1:BYTE_SEL_W] + LINE_W'(1);
  assign pop       = load && (state == S_SECOND || !cross);

  always_ff @(posedge clk) begin
    if (push) mem_len[wr_ptr] <= bus.in_len;
  end
`else
  logic unused_len;
  assign unused_len = ^bus.in_len;
  assign pop        = load;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= bus.in_addr;
      mem_cmd[wr_ptr]  <= bus.in_cmd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_cmd_q   <= '0;
      out_last_q  <= 1'b0;
`ifdef ADDR_SPLIT_CROSS_EN
      state       <= S_FIRST;
`endif
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_cmd_q   <= head_cmd;
`ifdef ADDR_SPLIT_CROSS_EN
      if (state == S_SECOND) begin
        out_addr_q <= {next_line, {BYTE_SEL_W{1'b0}}};
        out_last_q <= 1'b1;
        state      <= S_FIRST;
      end else if (cross) begin
        out_addr_q <= head_addr;
        out_last_q <= 1'b0;
        state      <= S_SECOND;
      end else begin
        out_addr_q <= head_addr;
        out_last_q <= 1'b1;
      end
`else
      out_addr_q  <= head_addr;
      out_last_q  <= 1'b1;
`endif
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_addr     = out_addr_q;
  assign bus.out_tag      = out_addr_q[ADDR_W-1 -: TAG_W];
  assign bus.out_index    = out_addr_q[BYTE_SEL_W +: INDEX_W];
  assign bus.out_byte_sel = out_addr_q[BYTE_SEL_W-1:0];
  assign bus.out_cmd      = out_cmd_q;
  assign bus.out_last     = out_last_q;
  assign count            = count_q;
endmodule

// File: tb/tb_addr_split_queue.sv
// Bench for addr_split_queue: directed scenarios plus random traffic against a beat-queue model.
// Honours ADDR_SPLIT_CROSS_EN the same way the design does.
module tb_addr_split_queue;
  localparam int LINE = 64;

  logic       clk;
  logic       rst_n;
  logic [2:0] count;

  addr_split_if #(.ADDR_W(32), .BYTE_SEL_W(6), .INDEX_W(14), .CMD_W(4)) bus ();

  addr_split_queue #(
    .ADDR_W(32), .BYTE_SEL_W(6), .INDEX_W(14), .DEPTH(4), .CMD_W(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .count (count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  cmd;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk = 0;
  int    n_bad = 0;
  int    n_acc = 0;
  logic  beat_seen;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected beats come straight from byte arithmetic on the record.
  task automatic model_push(input logic [31:0] a, input logic [5:0] l, input logic [3:0] c);
    longint unsigned off, nxt;
    off = a % LINE;
`ifdef ADDR_SPLIT_CROSS_EN
    if (off + l + 1 > LINE) begin
      nxt = ((longint'(a) / LINE) + 1) * LINE;
      exp_q.push_back('{a, c, 1'b0});
      exp_q.push_back('{nxt[31:0], c, 1'b1});
    end else begin
      exp_q.push_back('{a, c, 1'b1});
    end
`else
    if (off > LINE) chk("model_off", off, 0);
    exp_q.push_back('{a, c, 1'b1});
`endif
  endtask

  task automatic check_beat();
    beat_t e;
    chk("beat_expected", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("addr", bus.out_addr, e.addr);
      chk("tag", bus.out_tag, e.addr / (1 << 20));
      chk("index", bus.out_index, (e.addr / LINE) % 16384);
      chk("byte_sel", bus.out_byte_sel, e.addr % LINE);
      chk("cmd", bus.out_cmd, e.cmd);
      chk("last", bus.out_last, e.last);
    end
  endtask

  // Called at a negedge with inputs set; returns at the following negedge.
  task automatic cyc();
    logic fire_in, fire_out;
    #1;
    fire_in  = bus.in_valid && bus.in_ready;
    fire_out = bus.out_valid && bus.out_ready;
    beat_seen = fire_out;
    if (fire_out) check_beat();
    if (fire_in) begin
      model_push(bus.in_addr, bus.in_len, bus.in_cmd);
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [5:0] l, input logic [3:0] c);
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_len   = l;
    bus.in_cmd   = c;
  endtask

  task automatic drain(input string tag);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 200 && (exp_q.size() != 0 || bus.out_valid); k++) cyc();
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    int acc0;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 6'h0, 4'h0);
    bus.out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_addr", bus.out_addr, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_cmd", bus.out_cmd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", bus.in_ready, 1);
    chk("rel_out_valid", bus.out_valid, 0);

    // Single non-crossing record, one-cycle presentation latency.
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h1234_5678, 6'd0, 4'h5);
    cyc();
    drive(1'b0, 32'h0, 6'h0, 4'h0);
    chk("lat_early_valid", bus.out_valid, 0);
    cyc();
    chk("lat_valid", bus.out_valid, 1);
    chk("lat_tag", bus.out_tag, 12'h123);
    chk("lat_index", bus.out_index, 14'h1159);
    chk("lat_byte_sel", bus.out_byte_sel, 6'h38);
    chk("lat_last", bus.out_last, 1);
    drain("drain_single");

    // Record straddling the first line boundary.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h0000_003C, 6'd7, 4'hA);
    cyc();
    drive(1'b0, 32'h0, 6'h0, 4'h0);
    cyc();
    chk("x_b1_addr", bus.out_addr, 32'h3C);
    chk("x_b1_index", bus.out_index, 0);
    chk("x_b1_byte_sel", bus.out_byte_sel, 6'h3C);
    chk("x_b1_cmd", bus.out_cmd, 4'hA);
`ifdef ADDR_SPLIT_CROSS_EN
    chk("x_b1_last", bus.out_last, 0);
`else
    chk("x_b1_last", bus.out_last, 1);
`endif
    bus.out_ready = 1'b1;
    cyc();
`ifdef ADDR_SPLIT_CROSS_EN
    chk("x_b2_valid", bus.out_valid, 1);
    chk("x_b2_addr", bus.out_addr, 32'h40);
    chk("x_b2_index", bus.out_index, 1);
    chk("x_b2_byte_sel", bus.out_byte_sel, 0);
    chk("x_b2_cmd", bus.out_cmd, 4'hA);
    chk("x_b2_last", bus.out_last, 1);
`else
    chk("x_single_beat", bus.out_valid, 0);
`endif
    drain("drain_cross");

    // Top-of-memory wrap and full-line-from-zero records.
    drive(1'b1, 32'hFFFF_FFF8, 6'd15, 4'h7);
    cyc();
    drive(1'b1, 32'h0000_1000, 6'd63, 4'h2);
    cyc();
    drive(1'b1, 32'h0000_1001, 6'd63, 4'h3);
    cyc();
    drain("drain_wrap");

    // Capacity: four in the FIFO plus one in the output register.
    bus.out_ready = 1'b0;
    acc0 = n_acc;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h0000_0100 + 32'(i * 128), 6'd0, 4'(i));
      cyc();
    end
    drive(1'b0, 32'h0, 6'h0, 4'h0);
    chk("cap_accepted", n_acc - acc0, 5);
    chk("cap_count", count, 4);
    chk("cap_in_ready", bus.in_ready, 0);
    chk("cap_out_valid", bus.out_valid, 1);
    drain("drain_cap");
    chk("cap_count_empty", count, 0);

    // Reset while a record is mid-split with more queued behind it.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h0000_007C, 6'd8, 4'h3);
    cyc();
    drive(1'b1, 32'h0000_0200, 6'd1, 4'h4);
    cyc();
    drive(1'b1, 32'h0000_0300, 6'd1, 4'h5);
    cyc();
    drive(1'b0, 32'h0, 6'h0, 4'h0);
    bus.out_ready = 1'b1;
    beat_seen = 1'b0;
    for (int k = 0; k < 20 && !beat_seen; k++) cyc();
    chk("mid_beat_seen", beat_seen, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("post_rst_valid", bus.out_valid, 0);
      cyc();
    end

    // Random traffic with random backpressure.
    for (int k = 0; k < 600; k++) begin
      drive(1'b0, 32'h0, 6'h0, 4'h0);
      if ($urandom_range(0, 9) < 7) begin
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 3) == 0) a = {$urandom_range(0, 1) == 0 ? 26'h3FF_FFFF : 26'($urandom), 6'($urandom)};
        drive(1'b1, a, 6'($urandom), 4'($urandom));
      end
      bus.out_ready = ($urandom_range(0, 9) < 6);
      cyc();
    end
    drain("drain_random");
    chk("final_count", count, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/addr_split_queue.md
# addr_split_queue

Parametrised, queued successor to the combinational address splitter in the L2 cache simulator front end. It accepts trace records (address, command, access length) over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. Each record is emitted as one or two registered output beats split into tag, index and byte-select fields; a second beat is produced when the access crosses a cache-line boundary. The block sits between the trace reader and the cache controller.

## Interface
- ADDR_W, 32: address width
- BYTE_SEL_W, 6: byte-select bits (line size = 2^BYTE_SEL_W bytes)
- INDEX_W, 14: set-index bits
- TAG_W, ADDR_W-INDEX_W-BYTE_SEL_W: tag bits (derived, not overridden)
- DEPTH, 4: FIFO entries, power of two, ≥2
- CMD_W, 4: trace command width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  record offered
- in_ready  out  1  record accepted when in_valid && in_ready
- in_addr  in  ADDR_W  byte address
- in_cmd  in  CMD_W  command, passed through
- in_len  in  BYTE_SEL_W  access length minus one, in bytes
- out_valid  out  1  beat valid
- out_ready  in  1  beat consumed when out_valid && out_ready
- out_addr  out  ADDR_W  beat address
- out_tag  out  TAG_W  out_addr[ADDR_W-1 : BYTE_SEL_W+INDEX_W]
- out_index  out  INDEX_W  out_addr[BYTE_SEL_W+INDEX_W-1 : BYTE_SEL_W]
- out_byte_sel  out  BYTE_SEL_W  out_addr[BYTE_SEL_W-1:0]
- out_cmd  out  CMD_W  record command, identical on both beats
- out_last  out  1  final beat of the record
- count  out  $clog2(DEPTH+1)  FIFO occupancy, excluding the output register

## Operation
- FIFO: circular buffer with wrapping read/write pointers. in_ready = (count != DEPTH), driven from count only.
  - A full FIFO does not accept a push even in a cycle where it pops.
  - Push and pop in the same cycle leave count unchanged.
- Crossing detect: cross = carry out of the BYTE_SEL_W-bit sum head.addr[BYTE_SEL_W-1:0] + head.len.
- Splitter FSM:
  - S_FIRST → S_SECOND when a crossing head loads the output register as beat 1, with out_addr = head.addr and out_last = 0. The head stays in the FIFO.
  - S_SECOND → S_FIRST when beat 2 loads. Beat 2 has out_addr = ({head.addr[ADDR_W-1:BYTE_SEL_W], zeros} + 2^BYTE_SEL_W) mod 2^ADDR_W, byte_sel 0 and out_last = 1. The head is popped.
  - A non-crossing head loads one beat with out_last = 1 and is popped; the FSM stays in S_FIRST.
- Output register loads when (!out_valid || out_ready) and a beat is available, otherwise holds. Fields stay stable while out_valid && !out_ready.
- Tag, index and byte_sel are always slices of the registered out_addr.
- Address wrap: a second beat past 0xFFFF_FFC0 wraps to 0x0000_0000; no error is flagged.
- A record with in_len covering the full line from byte_sel 0 does not cross.

## Timing
- Reset (async assert, sync release):
  - Every output register and pointer clears: out_valid = 0, count = 0, all out_* = 0, FSM = S_FIRST.
  - in_ready = 1 during and after reset.
- Latency: a record pushed at edge N is presented with out_valid = 1 after edge N+1 when the output register is free.
- Throughput: one beat per cycle; a crossing record occupies two cycles.
- Reset mid-operation: any pending second beat and all queued records are discarded.
- Capacity: DEPTH records in the FIFO plus one beat in the output register.

## Configuration
- ADDR_SPLIT_CROSS_EN defined: line-crossing split as described.
- Not defined: the cross logic and S_SECOND are compiled out. Every record produces exactly one beat with out_addr = in_addr and out_last = 1.

## Test plan
- Push addr 0x1234_5678, len 0, out_ready = 1 → one cycle later out_valid = 1, tag 0x123, index 0x1159, byte_sel 0x38, out_last = 1.
- Push addr 0x0000_003C, len 7 → beat 1: addr 0x3C, index 0, byte_sel 0x3C, last 0. Beat 2: addr 0x40, index 1, byte_sel 0, last 1. Same out_cmd on both.
- Push addr 0xFFFF_FFF8, len 15 → beat 2 addr 0x0000_0000, tag 0, index 0, last 1.
- out_ready = 0, offer 6 records → 5 accepted (count = 4, output register full), in_ready = 0 on the 6th. Raise out_ready → 5 beats in push order, count falls to 0.
- Crossing record, drop rst_n after beat 1 is consumed → out_valid = 0 and count = 0 immediately. No beat 2 is seen after release.
- Macro undefined, repeat scenario 2 → single beat addr 0x3C, last 1.
